// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 VGA geometry for the timing generator and scenes.
// Holds region lengths, line/frame totals, sync-window bounds and coordinate width.
package vga_pkg;

    // Coordinate bus width and the largest total it can address.
    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal regions, in pixels.
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    // Vertical regions, in lines.
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync windows as half-open ranges [start, end).
    localparam int VGA_HS_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    // Registered per-pixel flags; all describe the same pixel as h/v_cnt.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic valid;
    } sync_t;

    // Idle pixel (0,0): syncs released, inside the visible area.
    localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, valid: 1'b1};

    // Unsigned test c in [lo, hi).
    function automatic logic in_window(coord_t c, int lo, int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// pix_tick_div: divides clk down to the pixel rate with a wrapping div_cnt.
// Ports: clk, rst_n (async, active-low) in; pix_tick out (last cycle of each pixel).
module pix_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    // With CLK_DIV=1 a single always-zero bit keeps pix_tick stuck high.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pix_tick_div: CLK_DIV must be >= 1");
    end

    logic [DW-1:0] div_cnt;

    assign pix_tick = (div_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pix_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel/line counters, active-low syncs, visible flag, strobes.
// Ports: clk, rst_n in; pix_tick, h_cnt, v_cnt, hsync, vsync, valid, line_end,
// frame_end out; frame_cnt out only when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_tick,
    output logic [COORD_W-1:0] h_cnt,
    output logic [COORD_W-1:0] v_cnt,
    output logic               hsync,
    output logic               vsync,
    output logic               valid,
    output logic               line_end,
`ifdef VGA_FRAME_COUNTER_EN
    output logic               frame_end,
    output logic [7:0]         frame_cnt
`else
    output logic               frame_end
`endif
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_geom
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate width");
    end

    coord_t h_nxt;
    coord_t v_nxt;
    logic   h_wrap;
    logic   v_wrap;
    sync_t  sync_nxt;
    sync_t  sync_q;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Next pixel position; h and v wrap on the same edge at frame end.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (pix_tick) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_nxt = h_cnt + 1'b1;
            end
        end
    end

    // Flags decoded from the next position so they land with the counters.
    always_comb begin
        sync_nxt       = SYNC_RST;
        sync_nxt.hsync = !in_window(h_nxt, HS_START, HS_END);
        sync_nxt.vsync = !in_window(v_nxt, VS_START, VS_END);
        sync_nxt.valid = in_window(h_nxt, 0, H_VIS) &&
                         in_window(v_nxt, 0, V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            sync_q <= SYNC_RST;
        end else begin
            h_cnt  <= h_nxt;
            v_cnt  <= v_nxt;
            sync_q <= sync_nxt;
        end
    end

    assign hsync = sync_q.hsync;
    assign vsync = sync_q.vsync;
    assign valid = sync_q.valid;

    assign line_end  = pix_tick && h_wrap;
    assign frame_end = line_end && v_wrap;

`ifdef VGA_FRAME_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen at CLK_DIV=4, CLK_DIV=1
// and a reduced geometry for frame wrap (and frame_cnt when enabled).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    logic rst2_n = 1'b0;

    logic       tick0, hs0, vs0, val0, le0, fe0;
    logic [9:0] h0, v0;
    logic       tick1, hs1, vs1, val1, le1, fe1;
    logic [9:0] h1, v1;
    logic       tick2, hs2, vs2, val2, le2, fe2;
    logic [9:0] h2, v2;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc0, fc1, fc2;
`endif

    vga_timing_gen #(.CLK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst0_n), .pix_tick(tick0),
        .h_cnt(h0), .v_cnt(v0), .hsync(hs0), .vsync(vs0),
        .valid(val0), .line_end(le0),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_end(fe0), .frame_cnt(fc0)
`else
        .frame_end(fe0)
`endif
    );

    vga_timing_gen #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .pix_tick(tick1),
        .h_cnt(h1), .v_cnt(v1), .hsync(hs1), .vsync(vs1),
        .valid(val1), .line_end(le1),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_end(fe1), .frame_cnt(fc1)
`else
        .frame_end(fe1)
`endif
    );

    // 8x8 frame: hsync low h=5..6, vsync low v=5..6, visible 4x4.
    vga_timing_gen #(
        .CLK_DIV(2),
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .pix_tick(tick2),
        .h_cnt(h2), .v_cnt(v2), .hsync(hs2), .vsync(vs2),
        .valid(val2), .line_end(le2),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_end(fe2), .frame_cnt(fc2)
`else
        .frame_end(fe2)
`endif
    );

    typedef struct {
        int k;
        int h;
        int v;
        bit hs;
        bit vs;
        bit val;
        bit tick;
        bit le;
    } vec_t;

    vec_t vt[$];

    int errors = 0;
    int checks = 0;
    int k;
    int n_hs, n_val, n_le, n_tl, n_vs, n_fe, n_bad;
    int first_hs, first_val, le_k, fe_k0, fe_k1;
    bit prev_fe;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        //              k     h    v  hs vs val tk le
        vt.push_back('{0,    0,   0, 1, 1, 1, 0, 0});
        vt.push_back('{3,    0,   0, 1, 1, 1, 1, 0});
        vt.push_back('{4,    1,   0, 1, 1, 1, 0, 0});
        vt.push_back('{2559, 639, 0, 1, 1, 1, 1, 0});
        vt.push_back('{2560, 640, 0, 1, 1, 0, 0, 0});
        vt.push_back('{2623, 655, 0, 1, 1, 0, 1, 0});
        vt.push_back('{2624, 656, 0, 0, 1, 0, 0, 0});
        vt.push_back('{3007, 751, 0, 0, 1, 0, 1, 0});
        vt.push_back('{3008, 752, 0, 1, 1, 0, 0, 0});
        vt.push_back('{3195, 798, 0, 1, 1, 0, 1, 0});
        vt.push_back('{3199, 799, 0, 1, 1, 0, 1, 1});
        vt.push_back('{3200, 0,   1, 1, 1, 1, 0, 0});
        vt.push_back('{3203, 0,   1, 1, 1, 1, 1, 0});
        vt.push_back('{3204, 1,   1, 1, 1, 1, 0, 0});

        repeat (3) @(negedge clk);

        // ---- DUT0 (CLK_DIV=4): reset values, then table ----
        check("rst.h_cnt", h0, 0);
        check("rst.v_cnt", v0, 0);
        check("rst.hsync", hs0, 1);
        check("rst.vsync", vs0, 1);
        check("rst.valid", val0, 1);
        check("rst.pix_tick", tick0, 0);
        check("rst.line_end", le0, 0);
        check("rst.frame_end", fe0, 0);
`ifdef VGA_FRAME_COUNTER_EN
        check("rst.frame_cnt", fc0, 0);
`endif
        rst0_n = 1'b1;
        k = 0;
        foreach (vt[i]) begin
            step(vt[i].k - k);
            k = vt[i].k;
            check($sformatf("vec%0d.h_cnt", i), h0, vt[i].h);
            check($sformatf("vec%0d.v_cnt", i), v0, vt[i].v);
            check($sformatf("vec%0d.hsync", i), hs0, vt[i].hs);
            check($sformatf("vec%0d.vsync", i), vs0, vt[i].vs);
            check($sformatf("vec%0d.valid", i), val0, vt[i].val);
            check($sformatf("vec%0d.pix_tick", i), tick0, vt[i].tick);
            check($sformatf("vec%0d.line_end", i), le0, vt[i].le);
            check($sformatf("vec%0d.frame_end", i), fe0, 0);
        end

        // ---- DUT0: monitor the rest of line 1 (k=3204..6399) ----
        n_hs = 0; n_val = 0; n_le = 0; n_bad = 0;
        first_hs = -1; first_val = -1; le_k = -1;
        for (int c = 0; c < 3196; c++) begin
            if (!hs0) begin
                n_hs++;
                if (first_hs < 0) first_hs = h0;
            end
            if (!val0) begin
                n_val++;
                if (first_val < 0) first_val = h0;
            end
            if (hs0 == (h0 >= 656 && h0 < 752)) n_bad++;
            if (le0) begin
                n_le++;
                le_k = k;
            end
            step(1);
            k++;
        end
        check("line.hsync_low_clks", n_hs, 384);
        check("line.hsync_first_h", first_hs, 656);
        check("line.hsync_window_err", n_bad, 0);
        check("line.valid_low_clks", n_val, 640);
        check("line.valid_first_low_h", first_val, 640);
        check("line.line_end_pulses", n_le, 1);
        check("line.length_clks", le_k - 3199, 3200);
        check("line.next_h", h0, 0);
        check("line.next_v", v0, 2);

        // ---- DUT0: asynchronous reset mid-line at (300,2) ----
        step(7603 - k);
        check("pre_rst.h_cnt", h0, 300);
        check("pre_rst.v_cnt", v0, 2);
        check("pre_rst.pix_tick", tick0, 1);
        #2 rst0_n = 1'b0;
        #1;
        check("async.h_cnt", h0, 0);
        check("async.v_cnt", v0, 0);
        check("async.pix_tick", tick0, 0);
        check("async.valid", val0, 1);
        check("async.hsync", hs0, 1);
        repeat (2) @(negedge clk);
        check("held.h_cnt", h0, 0);
        check("held.pix_tick", tick0, 0);
        rst0_n = 1'b1;
        step(3);
        check("restart.tick_k3", tick0, 1);
        check("restart.h_k3", h0, 0);
        step(1);
        check("restart.h_k4", h0, 1);
        check("restart.v_k4", v0, 0);
        check("restart.tick_k4", tick0, 0);

        // ---- DUT1 (CLK_DIV=1): one line ----
        check("div1.rst_tick", tick1, 1);
        check("div1.rst_line_end", le1, 0);
        rst1_n = 1'b1;
        n_hs = 0; n_val = 0; n_le = 0; n_tl = 0;
        first_hs = -1; le_k = -1;
        for (int c = 0; c < 800; c++) begin
            if (!tick1) n_tl++;
            if (!hs1) begin
                n_hs++;
                if (first_hs < 0) first_hs = h1;
            end
            if (!val1) n_val++;
            if (le1) begin
                n_le++;
                le_k = c;
            end
            step(1);
        end
        check("div1.tick_low_clks", n_tl, 0);
        check("div1.hsync_low_clks", n_hs, 96);
        check("div1.hsync_first_h", first_hs, 656);
        check("div1.valid_low_clks", n_val, 160);
        check("div1.line_end_pulses", n_le, 1);
        check("div1.line_end_k", le_k, 799);
        check("div1.next_h", h1, 0);
        check("div1.next_v", v1, 1);

        // ---- DUT2 (8x8, CLK_DIV=2): two frames ----
        rst2_n = 1'b1;
        n_fe = 0; n_le = 0; n_vs = 0; n_hs = 0; n_bad = 0;
        fe_k0 = -1; fe_k1 = -1; prev_fe = 1'b0;
        for (int c = 0; c < 256; c++) begin
            if (prev_fe && (h2 != 0 || v2 != 0)) n_bad++;
            if (vs2 == (v2 >= 5 && v2 < 7)) n_bad++;
            if (!vs2) n_vs++;
            if (!hs2) n_hs++;
            if (le2) n_le++;
            if (fe2) begin
                n_fe++;
                if (fe_k0 < 0) fe_k0 = c;
                else fe_k1 = c;
            end
            if (c == 127) begin
                check("small.fe_h", h2, 7);
                check("small.fe_v", v2, 7);
            end
`ifdef VGA_FRAME_COUNTER_EN
            if (c == 0) check("fcnt.k0", fc2, 0);
            if (c == 128) check("fcnt.k128", fc2, 1);
`endif
            prev_fe = fe2;
            step(1);
        end
        check("small.frame_end_pulses", n_fe, 2);
        check("small.first_fe_k", fe_k0, 127);
        check("small.frame_period", fe_k1 - fe_k0, 128);
        check("small.line_end_pulses", n_le, 16);
        check("small.vsync_low_clks", n_vs, 64);
        check("small.hsync_low_clks", n_hs, 64);
        check("small.wrap_or_vsync_err", n_bad, 0);
        check("small.after_h", h2, 0);
        check("small.after_v", v2, 0);
        check("small.after_valid", val2, 1);

`ifdef VGA_FRAME_COUNTER_EN
        step(128 * 255 - 256);
        check("fcnt.255", fc2, 255);
        step(128);
        check("fcnt.wrap0", fc2, 0);
        step(128);
        check("fcnt.1", fc2, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
